// File: rtl/movegen_sched.sv
// movegen_sched: kicks the eight column generators, then drains their FIFOs a..h.
// Optional WAIT watchdog: define MOVEGEN_WATCHDOG_EN.
module movegen_sched #(
    parameter int TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   col_done,
    input  logic [7:0]   col_empty,
    input  logic [151:0] col_rd_data,
    output logic [7:0]   col_start,
    output logic [7:0]   col_rden,
    output logic [18:0]  mv_data,
    output logic         mv_valid,
    input  logic         mv_ready,
    output logic         mv_last,
    output logic [7:0]   mv_count,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE, KICK, WAIT, SCAN, READ, CAP, EMIT, TERM
    } state_t;

    localparam logic [18:0] TERM_WORD = 19'h40000;

    state_t      state;
    logic [2:0]  ptr;
    logic [18:0] cap_word;
    logic        last_col;

    assign cap_word = col_rd_data[19*ptr +: 19];
    assign last_col = (ptr == 3'd7);

`ifdef MOVEGEN_WATCHDOG_EN
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
    logic [9:0] tmo_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^10'(TIMEOUT);
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            col_start <= '0;
            col_rden  <= '0;
            mv_data   <= '0;
            mv_valid  <= 1'b0;
            mv_last   <= 1'b0;
            mv_count  <= '0;
            busy      <= 1'b0;
`ifdef MOVEGEN_WATCHDOG_EN
            tmo_cnt   <= '0;
            err       <= 1'b0;
`endif
        end else begin
            col_start <= '0;
            col_rden  <= '0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= KICK;
                        col_start <= 8'hFF;
                        busy      <= 1'b1;
                        ptr       <= '0;
                        mv_count  <= '0;
`ifdef MOVEGEN_WATCHDOG_EN
                        tmo_cnt   <= '0;
                        err       <= 1'b0;
`endif
                    end
                end
                KICK: state <= WAIT;
                WAIT: begin
                    if (col_done == 8'hFF) begin
                        state <= SCAN;
                    end else begin
`ifdef MOVEGEN_WATCHDOG_EN
                        // give up on stuck columns; close list empty
                        if (tmo_cnt == TMO_LAST) begin
                            err      <= 1'b1;
                            state    <= TERM;
                            mv_data  <= TERM_WORD;
                            mv_valid <= 1'b1;
                            mv_last  <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 10'd1;
                        end
`endif
                    end
                end
                SCAN: begin
                    if (!col_empty[ptr]) begin
                        state    <= READ;
                        col_rden <= 8'd1 << ptr;
                    end else if (last_col) begin
                        state    <= TERM;
                        mv_data  <= TERM_WORD;
                        mv_valid <= 1'b1;
                        mv_last  <= 1'b1;
                    end else begin
                        ptr <= ptr + 3'd1;
                    end
                end
                READ: state <= CAP;
                CAP: begin
                    // bit 18 marks the end of a column's list
                    if (cap_word[18]) begin
                        if (last_col) begin
                            state    <= TERM;
                            mv_data  <= TERM_WORD;
                            mv_valid <= 1'b1;
                            mv_last  <= 1'b1;
                        end else begin
                            ptr   <= ptr + 3'd1;
                            state <= SCAN;
                        end
                    end else begin
                        mv_data  <= cap_word;
                        mv_valid <= 1'b1;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (mv_ready) begin
                        mv_valid <= 1'b0;
                        if (mv_count != 8'hFF)
                            mv_count <= mv_count + 8'd1;
                        state <= SCAN;
                    end
                end
                TERM: begin
                    if (mv_ready) begin
                        mv_valid <= 1'b0;
                        mv_last  <= 1'b0;
                        mv_data  <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_movegen_sched.sv
// Bench for movegen_sched: queue-based column FIFOs and a list-level
// reference model of the a..h drain order.
`timescale 1ns/1ps
module tb_movegen_sched;

    localparam logic [18:0] TERM_W = 19'h40000;
    localparam logic [18:0] MARK   = 19'h40000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   col_done = 8'h00;
    logic [7:0]   col_empty = 8'hFF;
    logic [151:0] col_rd_data;
    logic [7:0]   col_start;
    logic [7:0]   col_rden;
    logic [18:0]  mv_data;
    logic         mv_valid;
    logic         mv_ready = 1'b1;
    logic         mv_last;
    logic [7:0]   mv_count;
    logic         busy;
    logic         err;

    movegen_sched #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .col_done(col_done), .col_empty(col_empty),
        .col_rd_data(col_rd_data), .col_start(col_start),
        .col_rden(col_rden), .mv_data(mv_data),
        .mv_valid(mv_valid), .mv_ready(mv_ready),
        .mv_last(mv_last), .mv_count(mv_count),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // column FIFO models
    logic [18:0] fq[8][$];
    logic [18:0] rd_reg[8];
    logic [18:0] fifo_w;

    initial for (int i = 0; i < 8; i++) rd_reg[i] = '0;

    for (genvar g = 0; g < 8; g++) begin : g_rd
        assign col_rd_data[19*g +: 19] = rd_reg[g];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (col_rden[i] && fq[i].size() > 0) begin
                fifo_w = fq[i].pop_front();
                rd_reg[i] <= fifo_w;
            end
            col_empty[i] <= (fq[i].size() == 0);
        end
    end

    bit rdy_rand = 1'b0;
    always @(posedge clk)
        if (rdy_rand) begin
            #1 mv_ready = 1'($urandom_range(0, 1));
        end

    // stream monitor
    logic [18:0] got[$];
    logic [18:0] exp_q[$];
    int          term_seen = 0;
    logic [18:0] term_data;
    logic [7:0]  term_cnt;
    int          viol = 0;
    int          kicks = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [18:0] pd;

    always @(negedge clk) begin
        if (!reset) begin
            pv = 1'b0;
        end else begin
            if (col_start != 8'h00) begin
                kicks++;
                if (col_start != 8'hFF) viol++;
            end
            if ($countones(col_rden) > 1) viol++;
            if (col_rden != 8'h00 && mv_valid) viol++;
            if (mv_last && !mv_valid) viol++;
            if (pv && !pr && (!mv_valid || mv_data != pd)) viol++;
            if (mv_valid && mv_ready) begin
                if (mv_last) begin
                    term_seen++;
                    term_data = mv_data;
                    term_cnt  = mv_count;
                end else begin
                    got.push_back(mv_data);
                end
            end
            pv = mv_valid;
            pr = mv_ready;
            pd = mv_data;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // reference: each column's words in file order up to its end marker
    function automatic void build_exp();
        logic [18:0] w;
        exp_q.delete();
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < fq[c].size(); k++) begin
                w = fq[c][k];
                if (w[18]) break;
                exp_q.push_back(w);
            end
    endfunction

    function automatic int list_diffs();
        int d = 0;
        if (got.size() != exp_q.size()) return -1;
        for (int k = 0; k < got.size(); k++)
            if (got[k] !== exp_q[k]) d++;
        return d;
    endfunction

    function automatic logic [7:0] exp_cnt();
        return (exp_q.size() > 255) ? 8'd255 : 8'(exp_q.size());
    endfunction

    task automatic prep();
        for (int c = 0; c < 8; c++) fq[c].delete();
        got.delete();
        viol = 0;
        kicks = 0;
        term_seen = 0;
    endtask

    task automatic load_two();
        fq[0].push_back(19'h0000C);
        fq[0].push_back(19'h00014);
        fq[0].push_back(MARK);
        for (int c = 1; c < 8; c++) fq[c].push_back(MARK);
    endtask

    task automatic start_list(input int dly, output int lat);
        int n;
        build_exp();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (dly) @(posedge clk);
        #1 col_done = 8'hFF;
        n = 0;
        while (n < 60 && col_rden == 8'h00 && !mv_last) begin
            @(negedge clk);
            n++;
        end
        lat = n - 1;
    endtask

    task automatic wait_term(output bit ok);
        int n = 0;
        while (n < 20000 && term_seen == 0) begin
            @(negedge clk);
            n++;
        end
        ok = (term_seen != 0);
        @(posedge clk); #1 col_done = 8'h00;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (col_start !== 8'h00) $display("FAIL rst_col_start: got %h want 00", col_start); else passes++;
        checks++; if (col_rden !== 8'h00) $display("FAIL rst_col_rden: got %h want 00", col_rden); else passes++;
        checks++; if (mv_valid !== 1'b0) $display("FAIL rst_mv_valid: got %b want 0", mv_valid); else passes++;
        checks++; if (mv_last !== 1'b0) $display("FAIL rst_mv_last: got %b want 0", mv_last); else passes++;
        checks++; if (mv_data !== 19'h0) $display("FAIL rst_mv_data: got %h want 0", mv_data); else passes++;
        checks++; if (mv_count !== 8'h00) $display("FAIL rst_mv_count: got %0d want 0", mv_count); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else passes++;
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_two_moves();
        int lat;
        bit ok;
        prep();
        load_two();
        rdy_rand = 1'b0;
        mv_ready = 1'b1;
        start_list(5, lat);
        wait_term(ok);
        checks++; if (lat != 2) $display("FAIL two_rden_lat: got %0d want 2", lat); else passes++;
        checks++; if (!ok) $display("FAIL two_term: got none want 1"); else passes++;
        checks++; if (got.size() != 2) $display("FAIL two_len: got %0d want 2", got.size()); else passes++;
        checks++; if (list_diffs() != 0) $display("FAIL two_words: got %0d diffs want 0", list_diffs()); else passes++;
        checks++; if (term_data !== TERM_W) $display("FAIL two_term_word: got %h want %h", term_data, TERM_W); else passes++;
        checks++; if (term_cnt !== 8'd2) $display("FAIL two_count: got %0d want 2", term_cnt); else passes++;
        checks++; if (viol != 0 || kicks != 1) $display("FAIL two_proto: got viol=%0d kicks=%0d want 0/1", viol, kicks); else passes++;
    endtask

    task automatic test_stall();
        int lat;
        int n;
        bit ok;
        prep();
        load_two();
        rdy_rand = 1'b0;
        mv_ready = 1'b0;
        start_list(5, lat);
        n = 0;
        while (n < 50 && !mv_valid) begin
            @(negedge clk);
            n++;
        end
        checks++; if (mv_data !== 19'h0000C || !mv_valid) $display("FAIL stall_first: got %h/%b want 0000c/1", mv_data, mv_valid); else passes++;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (mv_data !== 19'h0000C || !mv_valid || col_rden !== 8'h00)
                $display("FAIL stall_hold: got %h/%b rden=%h want 0000c/1/00", mv_data, mv_valid, col_rden);
            else passes++;
        end
        @(posedge clk); #1 mv_ready = 1'b1;
        wait_term(ok);
        checks++; if (!ok) $display("FAIL stall_term: got none want 1"); else passes++;
        checks++; if (list_diffs() != 0) $display("FAIL stall_words: got %0d diffs want 0", list_diffs()); else passes++;
        checks++; if (term_cnt !== 8'd2) $display("FAIL stall_count: got %0d want 2", term_cnt); else passes++;
        checks++; if (viol != 0) $display("FAIL stall_proto: got %0d violations want 0", viol); else passes++;
    endtask

    task automatic test_skip_empty();
        int lat;
        bit ok;
        prep();
        fq[1].push_back(19'h1A2B3);
        fq[6].push_back(19'h0F0F0);
        rdy_rand = 1'b0;
        mv_ready = 1'b1;
        start_list(3, lat);
        wait_term(ok);
        checks++; if (lat != 3) $display("FAIL skip_rden_lat: got %0d want 3", lat); else passes++;
        checks++; if (!ok) $display("FAIL skip_term: got none want 1"); else passes++;
        checks++; if (list_diffs() != 0) $display("FAIL skip_words: got %0d diffs want 0", list_diffs()); else passes++;
        checks++; if (term_cnt !== 8'd2) $display("FAIL skip_count: got %0d want 2", term_cnt); else passes++;
        checks++; if (viol != 0) $display("FAIL skip_proto: got %0d violations want 0", viol); else passes++;
    endtask

    task automatic test_reset_mid_emit();
        int lat;
        int n;
        bit ok;
        prep();
        load_two();
        rdy_rand = 1'b0;
        mv_ready = 1'b1;
        start_list(3, lat);
        n = 0;
        while (n < 50 && got.size() < 1) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1 mv_ready = 1'b0;
        n = 0;
        while (n < 50 && !mv_valid) begin
            @(negedge clk);
            n++;
        end
        checks++; if (!mv_valid || mv_count !== 8'd1) $display("FAIL rme_pre: got valid=%b cnt=%0d want 1/1", mv_valid, mv_count); else passes++;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mv_valid !== 1'b0 || mv_data !== 19'h0 || mv_count !== 8'h00 || busy !== 1'b0 || mv_last !== 1'b0 || col_rden !== 8'h00)
            $display("FAIL rme_clear: got v=%b d=%h c=%0d b=%b l=%b r=%h want all 0", mv_valid, mv_data, mv_count, busy, mv_last, col_rden);
        else passes++;
        checks++; if (term_seen != 0) $display("FAIL rme_noterm: got %0d terminators want 0", term_seen); else passes++;
        @(posedge clk); #1 reset = 1'b1;
        col_done = 8'h00;
        mv_ready = 1'b1;
        repeat (2) @(posedge clk);
        prep();
        load_two();
        start_list(4, lat);
        wait_term(ok);
        checks++; if (!ok || list_diffs() != 0) $display("FAIL rme_clean: got ok=%b diffs=%0d want 1/0", ok, list_diffs()); else passes++;
        checks++; if (term_cnt !== 8'd2) $display("FAIL rme_count: got %0d want 2", term_cnt); else passes++;
    endtask

    task automatic test_random();
        int lat;
        bit ok;
        for (int it = 0; it < 6; it++) begin
            prep();
            for (int c = 0; c < 8; c++) begin
                int n;
                n = $urandom_range(0, 4);
                for (int k = 0; k < n; k++)
                    fq[c].push_back(19'($urandom_range(0, 32'h3FFFF)));
                if ($urandom_range(0, 1) == 1) begin
                    fq[c].push_back(MARK | 19'($urandom_range(0, 32'h3FFFF)));
                    if ($urandom_range(0, 1) == 1)
                        fq[c].push_back(19'($urandom_range(0, 32'h7FFFF)));
                end
            end
            rdy_rand = 1'b1;
            start_list($urandom_range(2, 6), lat);
            @(posedge clk); #1;
            if (busy) begin
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
            wait_term(ok);
            checks++; if (!ok) $display("FAIL rnd_term[%0d]: got none want 1", it); else passes++;
            checks++; if (list_diffs() != 0) $display("FAIL rnd_words[%0d]: got %0d diffs (n=%0d) want 0 (n=%0d)", it, list_diffs(), got.size(), exp_q.size()); else passes++;
            checks++; if (term_cnt !== exp_cnt()) $display("FAIL rnd_count[%0d]: got %0d want %0d", it, term_cnt, exp_cnt()); else passes++;
            checks++; if (viol != 0 || kicks != 1) $display("FAIL rnd_proto[%0d]: got viol=%0d kicks=%0d want 0/1", it, viol, kicks); else passes++;
        end
        rdy_rand = 1'b0;
        @(posedge clk); #1 mv_ready = 1'b1;
    endtask

    task automatic test_saturate();
        int lat;
        bit ok;
        int c;
        prep();
        for (int k = 0; k < 300; k++) begin
            c = k / 38;
            fq[c].push_back({1'b0, 6'($urandom_range(0, 63)), 12'(k)});
        end
        for (int i = 0; i < 8; i += 2) fq[i].push_back(MARK);
        rdy_rand = 1'b1;
        start_list(2, lat);
        wait_term(ok);
        rdy_rand = 1'b0;
        @(posedge clk); #1 mv_ready = 1'b1;
        checks++; if (!ok) $display("FAIL sat_term: got none want 1"); else passes++;
        checks++; if (got.size() != 300) $display("FAIL sat_len: got %0d want 300", got.size()); else passes++;
        checks++; if (list_diffs() != 0) $display("FAIL sat_words: got %0d diffs want 0", list_diffs()); else passes++;
        checks++; if (term_cnt !== 8'd255) $display("FAIL sat_count: got %0d want 255", term_cnt); else passes++;
        checks++; if (viol != 0) $display("FAIL sat_proto: got %0d violations want 0", viol); else passes++;
    endtask

`ifdef MOVEGEN_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        bit ok;
        prep();
        fq[3].push_back(19'h00ABC);
        fq[3].push_back(MARK);
        build_exp();
        rdy_rand = 1'b0;
        mv_ready = 1'b1;
        col_done = 8'h7F;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (n < 20 && col_start == 8'h00) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (n < 100 && !err) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 17) $display("FAIL wd_lat: got %0d want 17", n); else passes++;
        wait_term(ok);
        checks++; if (!ok || got.size() != 0) $display("FAIL wd_term: got ok=%b moves=%0d want 1/0", ok, got.size()); else passes++;
        checks++; if (term_cnt !== 8'd0) $display("FAIL wd_count: got %0d want 0", term_cnt); else passes++;
        checks++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL wd_sticky: got err=%b busy=%b want 1/0", err, busy); else passes++;
        term_seen = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b0) $display("FAIL wd_clear: got %b want 0", err); else passes++;
        @(posedge clk); #1 col_done = 8'hFF;
        wait_term(ok);
        checks++; if (!ok || list_diffs() != 0 || term_cnt !== 8'd1) $display("FAIL wd_rerun: got ok=%b diffs=%0d cnt=%0d want 1/0/1", ok, list_diffs(), term_cnt); else passes++;
    endtask
`else
    task automatic test_no_timeout();
        bit ok;
        prep();
        fq[3].push_back(19'h00ABC);
        fq[3].push_back(MARK);
        build_exp();
        rdy_rand = 1'b0;
        mv_ready = 1'b1;
        col_done = 8'h7F;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (err !== 1'b0 || busy !== 1'b1 || mv_valid !== 1'b0) $display("FAIL nto_wait: got err=%b busy=%b v=%b want 0/1/0", err, busy, mv_valid); else passes++;
        @(posedge clk); #1 col_done = 8'hFF;
        wait_term(ok);
        checks++; if (!ok || list_diffs() != 0) $display("FAIL nto_list: got ok=%b diffs=%0d want 1/0", ok, list_diffs()); else passes++;
        checks++; if (term_cnt !== 8'd1) $display("FAIL nto_count: got %0d want 1", term_cnt); else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_two_moves();
        test_stall();
        test_skip_empty();
        test_reset_mid_emit();
        test_random();
        test_saturate();
`ifdef MOVEGEN_WATCHDOG_EN
        test_watchdog();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/movegen_sched.md
# movegen_sched

Board-level move-generation scheduler. Starts all eight column units of a position evaluation and waits for their done flags. Then drains each column's move FIFO in file order (a→h) into a single 19-bit move stream with a valid/ready handshake. Sits between the eight column units and the downstream search/ordering logic. Closes each list with a terminator word and a move count.

## Interface
Parameters:
- TIMEOUT, 1023: max cycles in WAIT before abort (10-bit counter).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse to begin a position; ignored unless idle.
- col_done  in  8  done flag per column; bit i = file i.
- col_empty  in  8  column FIFO empty flag.
- col_rd_data  in  152  column i move word at [19*i+18 : 19*i].
- col_start  out  8  one-cycle pulse to all columns; all bits equal.
- col_rden  out  8  one-hot read strobe, at most one bit high.
- mv_data  out  19  move word: [18:12] flags [invalid, promote, pawn, pawn2, ep, castle, capture]; [11:6] from; [5:0] to.
- mv_valid  out  1  mv_data valid.
- mv_ready  in  1  downstream accepts when mv_valid && mv_ready.
- mv_last  out  1  high with the terminator word only.
- mv_count  out  8  moves emitted this list, terminator excluded; saturates at 255.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag; cleared by next accepted start.

## Operation
- States: IDLE, KICK, WAIT, SCAN, READ, CAP, EMIT, TERM.
- IDLE → KICK on start. Clear mv_count, err, timeout counter and col ptr (ptr=0).
- KICK: col_start=8'hFF for exactly one cycle → WAIT.
- WAIT: → SCAN when col_done==8'hFF. Timeout counter increments each WAIT cycle. With the watchdog compiled in, counter reaching TIMEOUT sets err → TERM.
- SCAN: if col_empty[ptr]==0 → READ. Otherwise, if ptr==7 → TERM; else ptr+1, stay in SCAN. One column tested per cycle.
- READ: col_rden[ptr]=1 for one cycle → CAP.
- CAP: capture col_rd_data[ptr] (valid the cycle after rden).
  - Word with bit 18 set is the column's in-band end marker. Discard it and treat the column as exhausted: ptr==7 → TERM, else ptr+1 → SCAN.
  - Otherwise load mv_data → EMIT.
- EMIT: mv_valid=1, mv_data held stable until mv_ready. On accept: mv_count+1 (saturating), → SCAN with the same ptr.
- TERM: mv_data = {1'b1, 6'o00, 6'o00, 6'o00}, mv_valid=1, mv_last=1. Hold until mv_ready → IDLE.
- start outside IDLE is ignored.
- col_empty going high mid-column ends that column the same as an end marker, detected in SCAN.

## Timing
- Reset values: col_start=0, col_rden=0, mv_valid=0, mv_last=0, mv_data=0, mv_count=0, busy=0, err=0; state IDLE, ptr=0.
- All outputs are registered.
- start → col_start high: 1 cycle.
- col_done==8'hFF → first col_rden: 2 cycles (SCAN, READ), plus 1 per empty column skipped.
- Per move with mv_ready held high: READ, CAP, EMIT, SCAN → one move per 4 cycles.
- No read issued while mv_valid is high. FIFOs never see a strobe while output backpressure is pending.
- Reset asserted mid-operation returns to IDLE immediately. A list in flight is abandoned and no terminator is emitted.

## Configuration
- MOVEGEN_WATCHDOG_EN defined: WAIT timeout active; err sets on expiry and the list is closed with the terminator only (mv_count=0).
- MOVEGEN_WATCHDOG_EN undefined: WAIT waits indefinitely; timeout counter removed; err tied 0.

## Test plan
- Reset mid-EMIT (mv_valid=1) → all outputs 0 next cycle, busy=0. A following start runs a clean list.
- Start pulse; columns done after 5 cycles; col 0 holds {0x0000C, 0x00014, end marker}; others hold only end markers → two moves emitted, then terminator with mv_last=1, mv_count=2.
- Same stimulus with mv_ready low for 3 cycles on the first move → mv_data stable 0x0000C through the stall, no col_rden during the stall, final mv_count=2.
- Columns 1 and 6 non-empty (1 move each), others col_empty=1 → moves emitted in order file 1 then file 6, empties skipped, mv_count=2.
- 300 moves spread across columns → mv_count saturates at 255, all 300 words emitted.
- MOVEGEN_WATCHDOG_EN, TIMEOUT=16, col_done=8'h7F forever → err=1 at cycle 16 of WAIT, terminator emitted, mv_count=0. Next start clears err.
